// File: rtl/rr_arb_mux_if.sv
// ---------------------------------------------------------------------------
// rr_arb_mux_if
// Bundles the handshake and data signals of rr_arb_mux.
//   mode      : 0 = round-robin, 1 = fixed select
//   sel_addr  : channel index used in fixed-select mode
//   in_valid  : per-channel valid (bit i = channel i)
//   in_ready  : per-channel ready, at most one bit high
//   in_data   : channel i at [i*WIDTH +: WIDTH]
//   in_last   : per-channel end-of-packet (only with RR_ARB_MUX_LOCK_EN)
//   out_valid / out_ready / out_data / out_sel : registered output stream
// Modports: slave = the arbiter, master = producers + consumer side.
// Optional macro: RR_ARB_MUX_LOCK_EN adds in_last.
// ---------------------------------------------------------------------------
interface rr_arb_mux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SELW = $clog2(CHANNELS);

    logic                      mode;
    logic [SELW-1:0]           sel_addr;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;
`ifdef RR_ARB_MUX_LOCK_EN
    logic [CHANNELS-1:0]       in_last;
`endif
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_sel;

    modport slave (
`ifdef RR_ARB_MUX_LOCK_EN
        input  in_last,
`endif
        input  mode, sel_addr, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
`ifdef RR_ARB_MUX_LOCK_EN
        output in_last,
`endif
        output mode, sel_addr, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_arb_mux.sv
// ---------------------------------------------------------------------------
// rr_arb_mux
// Selects one of CHANNELS valid/ready input streams into a single registered
// output stream, either by round-robin arbitration (mode=0) or by a fixed
// channel index (mode=1).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rr_arb_mux_if.slave (mode, sel_addr, in_valid/in_ready/in_data,
//           out_valid/out_ready/out_data/out_sel, optional in_last)
// Optional macro: RR_ARB_MUX_LOCK_EN - packet lock; once a channel sends a
// word without in_last, the grant stays on it until its last word transfers.
// The interface instance must use the same WIDTH/CHANNELS as this module.
// ---------------------------------------------------------------------------
module rr_arb_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arb_mux_if.slave   bus
);
    localparam int SELW = $clog2(CHANNELS);

    // Registered state
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;
    logic             lock_q,      lock_d;
    logic [SELW-1:0]  lock_ch_q,   lock_ch_d;

    // Grant
    logic             load_en;
    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic [CHANNELS-1:0] last_vec;

    // Per-channel data slices
    logic [WIDTH-1:0] chan_data [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slice
            assign chan_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef RR_ARB_MUX_LOCK_EN
    assign last_vec = bus.in_last;
`else
    // Without packet support every word is its own packet, so the lock
    // never engages.
    assign last_vec = '1;
`endif

    // The register may reload in the same cycle it drains.
    assign load_en = !out_valid_q || bus.out_ready;

    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        // rst_n gating keeps in_ready low for the whole reset interval.
        if (rst_n && load_en) begin
            if (lock_q) begin
                if (bus.in_valid[lock_ch_q]) begin
                    grant_vld = 1'b1;
                    grant_idx = lock_ch_q;
                end
            end else if (bus.mode) begin
                // Out-of-range select never grants.
                if ((int'(bus.sel_addr) < CHANNELS) && bus.in_valid[bus.sel_addr]) begin
                    grant_vld = 1'b1;
                    grant_idx = bus.sel_addr;
                end
            end else begin
                // Search starting at ptr and wrapping; first hit wins.
                for (int k = 0; k < CHANNELS; k++) begin
                    idx = (int'(ptr_q) + k) % CHANNELS;
                    if (!grant_vld && bus.in_valid[idx]) begin
                        grant_vld = 1'b1;
                        grant_idx = SELW'(idx);
                    end
                end
            end
        end
    end

    // A granted channel is by construction valid, so grant == transfer.
    assign bus.in_ready = grant_vld ? (CHANNELS'(1) << grant_idx) : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
        if (grant_vld) begin
            out_valid_d = 1'b1;
            out_data_d  = chan_data[grant_idx];
            out_sel_d   = grant_idx;
            lock_d      = !last_vec[grant_idx];
            lock_ch_d   = grant_idx;
            // Pointer moves past the winner only at a packet boundary.
            if (!bus.mode && last_vec[grant_idx]) begin
                ptr_d = (grant_idx == SELW'(CHANNELS - 1)) ? '0 : grant_idx + SELW'(1);
            end
        end else if (bus.out_ready) begin
            // Drain with nothing to replace it; data and sel keep last values.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// ---------------------------------------------------------------------------
// tb_rr_arb_mux
// Self-checking bench for rr_arb_mux (WIDTH=8, CHANNELS=4). Directed
// scenarios followed by randomized traffic, all compared against a
// cycle-level behavioural model. Build with +define+RR_ARB_MUX_LOCK_EN to
// exercise packet locking.
// ---------------------------------------------------------------------------
module tb_rr_arb_mux;
    localparam int W  = 8;
    localparam int CH = 4;

    logic clk;
    logic rst_n;

    rr_arb_mux_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

    rr_arb_mux #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit         m_valid;
    logic [7:0] m_data;
    int         m_sel;
    int         m_ptr;
    bit         m_lock;
    int         m_lock_ch;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0; m_lock = 0; m_lock_ch = 0;
    endfunction

    function automatic bit is_last(input int ch);
`ifdef RR_ARB_MUX_LOCK_EN
        return bus.in_last[ch];
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [7:0] data_of(input int ch);
        logic [CH*W-1:0] v;
        v = bus.in_data;
        return v[ch*W +: W];
    endfunction

    // Winner is the valid channel at the smallest circular distance from ptr.
    function automatic int model_grant();
        int best, bestd, d;
        if (m_valid && !bus.out_ready) return -1;
        if (m_lock) return bus.in_valid[m_lock_ch] ? m_lock_ch : -1;
        if (bus.mode) begin
            if (int'(bus.sel_addr) < CH && bus.in_valid[bus.sel_addr]) return int'(bus.sel_addr);
            return -1;
        end
        best = -1; bestd = CH;
        for (int i = 0; i < CH; i++) begin
            if (bus.in_valid[i]) begin
                d = (i - m_ptr + CH) % CH;
                if (d < bestd) begin bestd = d; best = i; end
            end
        end
        return best;
    endfunction

    function automatic void model_update(input int g);
        if (g >= 0) begin
            m_valid = 1; m_data = data_of(g); m_sel = g;
            m_lock = !is_last(g); m_lock_ch = g;
            if (!bus.mode && is_last(g)) m_ptr = (g + 1) % CH;
        end else if (bus.out_ready) begin
            m_valid = 0;
        end
    endfunction

    // One clock: check in_ready before the edge, outputs just after it.
    task automatic step(input string tag);
        int g;
        logic [63:0] exp_rdy;
        #1;
        g = model_grant();
        exp_rdy = (g >= 0) ? (64'd1 << g) : 64'd0;
        chk({tag, ".in_ready"}, 64'(bus.in_ready), exp_rdy);
        @(posedge clk);
        model_update(g);
        #1;
        chk({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_valid));
        chk({tag, ".out_data"},  64'(bus.out_data),  64'(m_data));
        chk({tag, ".out_sel"},   64'(bus.out_sel),   64'(m_sel));
        if (g >= 0) $display("%s: ch=%0d data=%02h", tag, g, m_data);
        @(negedge clk);
    endtask

    task automatic set_data(input logic [7:0] base, input logic [7:0] inc);
        for (int i = 0; i < CH; i++) bus.in_data[i*W +: W] = base + inc * 8'(i);
    endtask

    initial begin
        logic [7:0] held_data;
        int         held_sel;

        rst_n        = 1'b0;
        bus.mode     = 1'b0;
        bus.sel_addr = '0;
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
`ifdef RR_ARB_MUX_LOCK_EN
        bus.in_last  = '1;
`endif
        model_reset();

        // Reset state
        bus.in_valid = '1;
        @(negedge clk); @(negedge clk);
        chk("rst.in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.out_data",  64'(bus.out_data),  64'd0);
        rst_n = 1'b1;

        // Round-robin fairness
        bus.mode = 1'b0; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        set_data(8'hA0, 8'h01);
        for (int i = 0; i < 8; i++) begin
            step("rr");
            chk("rr.seq_sel",  64'(bus.out_sel),  64'(i % CH));
            chk("rr.seq_data", 64'(bus.out_data), 64'(8'hA0 + 8'(i % CH)));
        end

        // Fixed select
        bus.mode = 1'b1; bus.sel_addr = 2'd2; set_data(8'h11, 8'h11);
        for (int i = 0; i < 3; i++) begin
            step("fix");
            chk("fix.data33", 64'(bus.out_data), 64'h33);
        end
        bus.in_valid = 4'b1011;
        step("fix_idle");
        step("fix_idle");

        // Backpressure
        bus.mode = 1'b0; bus.in_valid = 4'b1111; set_data(8'h50, 8'h01);
        step("bp_load");
        held_data = bus.out_data; held_sel = int'(bus.out_sel);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("bp_stall");
            chk("bp.held_data", 64'(bus.out_data), 64'(held_data));
        end
        bus.out_ready = 1'b1;
        step("bp_release");
        chk("bp.reload_sel", 64'(bus.out_sel), 64'((held_sel + 1) % CH));

        // Pointer wrap and skip
        bus.in_valid = 4'b0100; step("wrap_prep");
        bus.in_valid = 4'b0010; step("wrap_skip");
        chk("wrap.sel1", 64'(bus.out_sel), 64'd1);
        bus.in_valid = 4'b0011; step("wrap_wrap");
        chk("wrap.sel0", 64'(bus.out_sel), 64'd0);

`ifdef RR_ARB_MUX_LOCK_EN
        // Packet lock: channel 1 sends three words while channel 2 waits
        bus.in_valid = 4'b0110;
        for (int w = 0; w < 3; w++) begin
            bus.in_last = 4'b1101 | (w == 2 ? 4'b0010 : 4'b0000);
            step("lock_pkt");
            chk("lock.sel1", 64'(bus.out_sel), 64'd1);
        end
        bus.in_last = 4'b1111;
        step("lock_after");
        chk("lock.sel2", 64'(bus.out_sel), 64'd2);
`endif

        // Asynchronous reset mid-cycle while holding a word
        bus.in_valid = 4'b1111; bus.out_ready = 1'b0;
        step("arst_load");
        chk("arst.pre_valid", 64'(bus.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst.out_data",  64'(bus.out_data),  64'd0);
        chk("arst.out_sel",   64'(bus.out_sel),   64'd0);
        chk("arst.in_ready",  64'(bus.in_ready),  64'd0);
        model_reset();
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1; bus.out_ready = 1'b1;
        step("arst_first");
        chk("arst.first_grant", 64'(bus.out_sel), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bus.mode      = ($urandom_range(0, 3) == 0);
            bus.sel_addr  = 2'($urandom_range(0, CH - 1));
            bus.in_valid  = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_data   = 32'($urandom);
`ifdef RR_ARB_MUX_LOCK_EN
            bus.in_last   = 4'($urandom) | 4'($urandom);
`endif
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised successor to the team's 2:1 combinational multiplexer.
- Selects one of CHANNELS valid/ready input streams of WIDTH bits into a single registered output stream.
- Two modes: round-robin arbitration, or fixed address select (the classic mux behaviour, now registered and flow-controlled).
- Sits between multiple producers, such as lab datapath units, and one shared consumer.

Parameters:
- WIDTH, 8, data width per channel, range 1 to 64.
- CHANNELS, 4, number of input channels, range 2 to 16.
- SELW, $clog2(CHANNELS), width of select/index fields. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  arbitration mode: 0 = round-robin, 1 = fixed select.
- sel_addr  input  SELW  channel index used when mode=1.
- in_valid  input  CHANNELS  per-channel valid; bit i belongs to channel i.
- in_ready  output  CHANNELS  per-channel ready; at most one bit high.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  registered data.
- out_sel  output  SELW  index of the channel that supplied out_data.

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
  - All in_ready bits read 0 while rst_n=0.
  - Reset mid-transfer discards the held word; no partial state survives.
- Load enable: load_en = !out_valid || out_ready. The output register accepts a new word while empty, or in the same cycle its word is drained. This gives full throughput of one word per cycle.
- Grant, combinational, evaluated only when load_en=1:
  - mode=0: grant the first channel i with in_valid[i]=1, searching ptr, ptr+1, ..., CHANNELS-1, 0, ..., ptr-1.
  - mode=1: grant sel_addr if in_valid[sel_addr]=1. Otherwise no grant.
  - mode=1 with sel_addr >= CHANNELS: no grant ever; in_ready stays all-zero.
- in_ready[i] = load_en && grant valid && grant==i.
  - in_ready may depend combinationally on out_ready, documented path.
  - in_ready never depends on in_data.
- Transfer on channel i when in_valid[i] && in_ready[i]. At the next edge:
  - out_data <= in_data[i], out_sel <= i, out_valid <= 1.
  - mode=0 only: ptr <= (i+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
- mode=1 leaves ptr unchanged.
- Drain without new grant (out_valid && out_ready && no grant): out_valid <= 0. out_data and out_sel hold their previous values.
- Stall (out_valid && !out_ready): out_data, out_sel and out_valid hold; all in_ready=0.
- Latency: one cycle from input handshake to out_valid.
- Ordering within a channel is preserved; nothing is duplicated or dropped.
- A mode or sel_addr change takes effect on the same cycle's grant decision. No output word is disturbed by the change.
- Inputs may deassert in_valid without a handshake; such a withdrawal is never granted retroactively.

Optional Feature:
- Macro: RR_ARB_MUX_LOCK_EN.
- Defined:
  - Adds input port in_last, width CHANNELS, marking the final word of a packet.
  - Once channel i is granted a word with in_last[i]=0, the grant locks to i, overriding mode and pointer, until a word with in_last[i]=1 transfers.
  - ptr advances only on that final word.
  - Reset clears the lock.
  - While locked, other channels see in_ready=0 even if channel i idles.
- Undefined:
  - No in_last port.
  - Every word is arbitrated independently as above.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle while out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately. First grant after release goes to channel 0 when all valid.
- Round-robin fairness: CHANNELS=4, mode=0, all in_valid=1, out_ready=1, in_data[i]=8'hA0+i -> out_sel sequence 0,1,2,3,0,... and out_data A0,A1,A2,A3,A0. One word per cycle.
- Fixed select: mode=1, sel_addr=2, in_valid=4'b1111, data 11/22/33/44 -> out_data=8'h33 every cycle; in_ready=4'b0100. With in_valid[2]=0, out_valid falls to 0 and in_ready=0.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, in_ready=0. Release -> the held word drains and a new word loads in the same cycle.
- Pointer wrap and skip: ptr=3, in_valid=4'b0010 -> channel 1 granted, then ptr=2. Next in_valid=4'b0011 -> channel 0 granted, since the search wraps from 3 to 0.
- RR_ARB_MUX_LOCK_EN: channel 1 sends a 3-word packet (in_last on the third word) while channel 2 is valid throughout -> out_sel=1,1,1, then 2.
